// File: rtl/wave_capture_if.sv
// Bus between the capture buffer and its sample source / display reader.
// master drives samples, arm and read address; slave is the capture buffer.
interface wave_capture_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               arm;
  logic [ADDR_W-1:0]  rd_addr;
  logic [15:0]        rd_data;
  logic               busy;
  logic               capture_done;
  logic               auto_trig;

  modport master (
    output sample_in, sample_valid, arm, rd_addr,
    input  rd_data, busy, capture_done, auto_trig
  );

  modport slave (
    input  sample_in, sample_valid, arm, rd_addr,
    output rd_data, busy, capture_done, auto_trig
  );
endinterface

// File: rtl/wave_capture.sv
// Oscilloscope-style capture buffer: waits for a rising zero crossing (or a timeout),
// stores a decimated window of samples and freezes it for synchronous readout.
module wave_capture #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DECIM   = 4,
  parameter int unsigned TIMEOUT = 4800
) (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.slave  bus
);

  localparam int unsigned Depth    = 1 << ADDR_W;
  localparam int unsigned DecimW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned TimeoutW = $clog2(TIMEOUT);

  localparam logic [DecimW-1:0]   DecimLast   = DecimW'(DECIM - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]   AddrLast    = '1;

  typedef enum logic [1:0] {StIdle, StPretrig, StCapture, StDone} state_e;

  state_e                state_q;
  logic                  prev_sign_q;  // only the sign of the previous sample matters
  logic [ADDR_W-1:0]     wr_ptr_q;
  logic [DecimW-1:0]     decim_cnt_q;
  logic [TimeoutW-1:0]   timeout_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  auto_trig_q;
  logic [15:0]           rd_data_q;
  logic [15:0]           mem [Depth];

  logic                  crossing;
  logic                  trig_timeout;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;

  assign crossing     = bus.sample_valid & prev_sign_q & ~bus.sample_in[15];
  assign trig_timeout = bus.sample_valid & (timeout_cnt_q == TimeoutLast);

  always_comb begin
    we    = 1'b0;
    waddr = wr_ptr_q;
    case (state_q)
      StPretrig: begin
        if (crossing || trig_timeout) begin
          we    = 1'b1;
          waddr = '0;
        end
      end
      StCapture: begin
        if (bus.sample_valid && (decim_cnt_q == DecimLast)) we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      prev_sign_q   <= 1'b0;
      wr_ptr_q      <= '0;
      decim_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      auto_trig_q   <= 1'b0;
    end else begin
      if (bus.sample_valid) prev_sign_q <= bus.sample_in[15];
      case (state_q)
        StIdle, StDone: begin
          if (bus.arm) begin
            state_q       <= StPretrig;
            timeout_cnt_q <= '0;
            auto_trig_q   <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
          end
        end
        StPretrig: begin
          if (bus.sample_valid) begin
            if (crossing || trig_timeout) begin
              state_q     <= StCapture;
              wr_ptr_q    <= ADDR_W'(1);
              decim_cnt_q <= '0;
              auto_trig_q <= ~crossing;  // a real crossing wins over a coincident timeout
            end else begin
              timeout_cnt_q <= timeout_cnt_q + 1'b1;
            end
          end
        end
        StCapture: begin
          if (bus.sample_valid) begin
            if (decim_cnt_q == DecimLast) begin
              decim_cnt_q <= '0;
              wr_ptr_q    <= wr_ptr_q + 1'b1;
              if (wr_ptr_q == AddrLast) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              decim_cnt_q <= decim_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sample RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= bus.sample_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= mem[bus.rd_addr];
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.busy         = busy_q;
  assign bus.capture_done = done_q;
  assign bus.auto_trig    = auto_trig_q;

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Oscilloscope-style capture buffer downstream of the music player.
- Consumes the final mixed sample stream (`sample_out`) qualified by the per-sample strobe (`new_sample_generated`).
- Waits for a rising zero crossing, then stores a decimated window of samples into on-chip RAM.
- Freezes the window so the display logic can read it out through a synchronous read port.

Parameters:
- ADDR_W, 8, log2 of buffer depth; buffer holds 2^ADDR_W samples.
- DECIM, 4, store one sample per DECIM input samples after trigger; legal range 1..255.
- TIMEOUT, 4800, number of sample strobes in PRETRIG with no crossing before a forced trigger; legal range 2..65535.

Ports:
- clk  input  1  system clock; the single clock for the block.
- reset  input  1  synchronous, active-low reset; the port keeps the codebase name but is asserted at 0.
- sample_in  input  16  signed two's-complement mixed sample from the music player.
- sample_valid  input  1  one-cycle strobe; sample_in is valid on this cycle.
- arm  input  1  one-cycle request from the display to start a new capture.
- rd_addr  input  ADDR_W  display read address.
- rd_data  output  16  registered RAM word at rd_addr, one-cycle latency.
- busy  output  1  high in PRETRIG or CAPTURE.
- capture_done  output  1  high in DONE; buffer is frozen and fully valid.
- auto_trig  output  1  last capture was forced by timeout; valid while capture_done.

Behaviour:
- Reset is sampled on clk while reset==0. It forces:
  - state to IDLE;
  - busy, capture_done and auto_trig to 0;
  - rd_data to 0;
  - prev_sample, wr_ptr, decim_cnt and timeout_cnt to 0.
- Reset does not clear RAM contents. Reset mid-capture abandons the capture immediately.
- prev_sample <= sample_in on every sample_valid, in every state. A rising crossing is defined as prev_sample[15]==1 and sample_in[15]==0 on a sample_valid cycle.
- States are IDLE, PRETRIG, CAPTURE and DONE.
- IDLE:
  - arm -> PRETRIG; clear timeout_cnt and auto_trig.
- PRETRIG:
  - On sample_valid with a crossing: write sample_in to addr 0, set wr_ptr=1, set decim_cnt=0, go to CAPTURE, auto_trig=0.
  - Else on sample_valid:
    - if timeout_cnt==TIMEOUT-1, force the trigger exactly as above and set auto_trig=1;
    - otherwise timeout_cnt+1.
  - A crossing on the same strobe as the timeout counts as a real trigger (auto_trig=0).
- CAPTURE:
  - On each sample_valid, decim_cnt increments.
  - When decim_cnt reaches DECIM-1 it wraps to 0, and that sample is written at wr_ptr, then wr_ptr+1.
  - So stored entry k equals input sample k*DECIM after the trigger sample.
  - With DECIM=1, every strobe writes.
  - The write of entry 2^ADDR_W-1 moves the block to DONE on the next cycle. wr_ptr does not wrap into a new capture.
- DONE:
  - capture_done=1; RAM is not written.
  - arm -> PRETRIG; capture_done drops the next cycle.
- arm in PRETRIG or CAPTURE is ignored.
- arm coincident with sample_valid in IDLE/DONE: the transition happens; that sample only updates prev_sample and is not tested for a crossing.
- Back-to-back sample_valid on consecutive cycles must be handled; there is no minimum spacing.
- busy and capture_done are registered state decodes and are never both high.
- Read port:
  - rd_data <= mem[rd_addr] every cycle; latency is 1 clk.
  - Reads during CAPTURE return an unspecified mix of old and new data.
  - A read and a write to the same address in one cycle returns the old word.
- Arithmetic: comparisons use the sign bit only; no sample arithmetic is performed. Counter widths must hold TIMEOUT-1 and DECIM-1 without overflow.

Test Plan:
- Real trigger: ADDR_W=3, DECIM=1. Arm, then stream -5,-3,2,7,9,… → trigger on 2; entries 0..7 = 2,7,9,…; capture_done=1 after the 8th write; auto_trig=0.
- Decimation: DECIM=4, ramp -1,0,1,2,… (crossing at 0) → entries = 0,4,8,…,28; wr_ptr advances only on every 4th strobe.
- Timeout: TIMEOUT=10, constant +100 input → forced trigger on the 10th strobe after arm; entry 0 = 100; auto_trig=1 when done.
- Ignored arm: pulse arm mid-CAPTURE → capture completes unchanged. Arm in DONE → capture_done falls in 1 clk and busy=1.
- Reset mid-capture: drive reset=0 for 1 clk at wr_ptr=3 → IDLE, all outputs 0. Next arm restarts at addr 0, and entries 0..2 are overwritten.
- Read latency and consecutive strobes: sample_valid held high 16 cycles with DECIM=2 → 8 entries captured correctly. Then step rd_addr 0..7 → rd_data matches exactly one cycle later.
